// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: widths, opcodes and instruction
// field positions.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_W  = 16;

endpackage

// File: rtl/instruction_decode_if.sv
// Bundle of the ID-stage signals: the surrounding pipeline is the master,
// the decode block is the slave.
interface instruction_decode_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
);
    logic [31:0]       instruction;
    logic [DATA_W-1:0] PCPlus4D;
    logic              RegWriteW;
    logic [REG_AW-1:0] WriteRegW;
    logic [DATA_W-1:0] ResultW;
    logic              RegWriteE;
    logic              MemReadE;
    logic [REG_AW-1:0] WriteRegE;
    logic              MemReadM;
    logic [REG_AW-1:0] WriteRegM;

    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic [REG_AW-1:0] RdD;
    logic [DATA_W-1:0] PCbranchD;
    logic              hazardDetected;
    logic              PCSrcD;
    logic              equalD;

    modport master (
        output instruction, PCPlus4D, RegWriteW, WriteRegW, ResultW,
               RegWriteE, MemReadE, WriteRegE, MemReadM, WriteRegM,
        input  data1, data2, RsD, RtD, RdD, PCbranchD, hazardDetected,
               PCSrcD, equalD
    );

    modport slave (
        input  instruction, PCPlus4D, RegWriteW, WriteRegW, ResultW,
               RegWriteE, MemReadE, WriteRegE, MemReadM, WriteRegM,
        output data1, data2, RsD, RtD, RdD, PCbranchD, hazardDetected,
               PCSrcD, equalD
    );
endinterface

// File: rtl/register_file.sv
// 2-read/1-write register file with async clear, r0 hardwired to zero and
// write-through bypass so an instruction in ID sees the WB result this cycle.
module register_file #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);
    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [REG_AW-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_wr_en;

    // Flops rather than RAM: the whole array must clear on reset.
    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign w_raddr[0] = i_raddr1;
    assign w_raddr[1] = i_raddr2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign w_rdata[gi] = (w_raddr[gi] == '0)                   ? '0      :
                             (w_wr_en && i_waddr == w_raddr[gi]) ? i_wdata :
                                                                   r_regs[w_raddr[gi]];
    end

    assign o_rdata1 = w_rdata[0];
    assign o_rdata2 = w_rdata[1];
endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: field split, operand read, early beq/bne resolution and
// hazard reporting. All outputs are combinational.
module instruction_decode #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_decode_if.slave   id_if
);
    logic [5:0]        w_opcode;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [DATA_W-1:0] w_sign_imm;
    logic [DATA_W-1:0] w_data1;
    logic [DATA_W-1:0] w_data2;
    logic              w_equal;
    logic              w_is_beq;
    logic              w_is_bne;
    logic              w_is_branch;
    logic              w_uses_rs;
    logic              w_uses_rt;
    logic              w_load_use;
    logic              w_branch_alu;
    logic              w_branch_load;

    assign w_opcode = id_if.instruction[mips_pkg::OP_HI:mips_pkg::OP_LO];
    assign w_rs     = id_if.instruction[mips_pkg::RS_HI:mips_pkg::RS_LO];
    assign w_rt     = id_if.instruction[mips_pkg::RT_HI:mips_pkg::RT_LO];

    assign id_if.RsD = w_rs;
    assign id_if.RtD = w_rt;
    assign id_if.RdD = id_if.instruction[mips_pkg::RD_HI:mips_pkg::RD_LO];

    assign w_sign_imm = {{(DATA_W-mips_pkg::IMM_W){id_if.instruction[mips_pkg::IMM_HI]}},
                         id_if.instruction[mips_pkg::IMM_HI:0]};
    assign id_if.PCbranchD = id_if.PCPlus4D + (w_sign_imm << 2);

    register_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_register_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (id_if.RegWriteW),
        .i_waddr  (id_if.WriteRegW),
        .i_wdata  (id_if.ResultW),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_data1),
        .o_rdata2 (w_data2)
    );

    assign id_if.data1  = w_data1;
    assign id_if.data2  = w_data2;
    assign w_equal      = (w_data1 == w_data2);
    assign id_if.equalD = w_equal;

    assign w_is_beq     = (w_opcode == mips_pkg::OP_BEQ);
    assign w_is_bne     = (w_opcode == mips_pkg::OP_BNE);
    assign w_is_branch  = w_is_beq || w_is_bne;
    assign id_if.PCSrcD = (w_is_beq && w_equal) || (w_is_bne && !w_equal);

    // Jumps carry a target in the rs/rt bit positions, so they never read rs.
    assign w_uses_rs = !((w_opcode == mips_pkg::OP_J) || (w_opcode == mips_pkg::OP_JAL));
    assign w_uses_rt = (w_opcode == mips_pkg::OP_RTYPE) || w_is_branch ||
                       (w_opcode == mips_pkg::OP_SW);

    assign w_load_use = id_if.MemReadE && (id_if.WriteRegE != '0) &&
                        (((id_if.WriteRegE == w_rs) && w_uses_rs) ||
                         ((id_if.WriteRegE == w_rt) && w_uses_rt));

    // Branches compare in ID, so producers still in EX or loads in MEM stall them.
    assign w_branch_alu = w_is_branch && id_if.RegWriteE && (id_if.WriteRegE != '0) &&
                          ((id_if.WriteRegE == w_rs) || (id_if.WriteRegE == w_rt));

    assign w_branch_load = w_is_branch && id_if.MemReadM && (id_if.WriteRegM != '0) &&
                           ((id_if.WriteRegM == w_rs) || (id_if.WriteRegM == w_rt));

    assign id_if.hazardDetected = w_load_use || w_branch_alu || w_branch_load;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: expectations are queued on a
// scoreboard as stimulus is applied, then popped and compared.
module tb_instruction_decode;

    typedef enum int {
        S_DATA1, S_DATA2, S_RS, S_RT, S_RD, S_PCBR, S_HAZ, S_PCSRC, S_EQ
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    sb_entry_t sb[$];

    instruction_decode_if id_if ();

    instruction_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .id_if (id_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observe(input sel_e sel);
        case (sel)
            S_DATA1: return id_if.data1;
            S_DATA2: return id_if.data2;
            S_RS:    return {27'd0, id_if.RsD};
            S_RT:    return {27'd0, id_if.RtD};
            S_RD:    return {27'd0, id_if.RdD};
            S_PCBR:  return id_if.PCbranchD;
            S_HAZ:   return {31'd0, id_if.hazardDetected};
            S_PCSRC: return {31'd0, id_if.PCSrcD};
            default: return {31'd0, id_if.equalD};
        endcase
    endfunction

    task automatic exp_val(input string tag, input sel_e sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
            $display("check %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] val);
        @(negedge clk);
        id_if.RegWriteW = 1'b1;
        id_if.WriteRegW = addr;
        id_if.ResultW   = val;
        @(posedge clk);
        #1;
        id_if.RegWriteW = 1'b0;
    endtask

    initial begin
        id_if.instruction = 32'h0043_0820;
        id_if.PCPlus4D    = 32'h0;
        id_if.RegWriteW   = 1'b0;
        id_if.WriteRegW   = 5'd0;
        id_if.ResultW     = 32'h0;
        id_if.RegWriteE   = 1'b0;
        id_if.MemReadE    = 1'b0;
        id_if.WriteRegE   = 5'd0;
        id_if.MemReadM    = 1'b0;
        id_if.WriteRegM   = 5'd0;

        // Reset state with add $1,$2,$3 in ID
        #12;
        exp_val("rst_rs", S_RS, 32'd2);
        exp_val("rst_rt", S_RT, 32'd3);
        exp_val("rst_rd", S_RD, 32'd1);
        exp_val("rst_data1", S_DATA1, 32'd0);
        exp_val("rst_data2", S_DATA2, 32'd0);
        exp_val("rst_equal", S_EQ, 32'd1);
        exp_val("rst_pcsrc", S_PCSRC, 32'd0);
        exp_val("rst_haz", S_HAZ, 32'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Write reg2=1: bypass during the write cycle, stored value afterwards
        @(negedge clk);
        id_if.RegWriteW = 1'b1;
        id_if.WriteRegW = 5'd2;
        id_if.ResultW   = 32'd1;
        exp_val("bypass_data1", S_DATA1, 32'd1);
        exp_val("bypass_eq", S_EQ, 32'd0);
        drain();
        @(posedge clk);
        #1;
        id_if.RegWriteW = 1'b0;
        exp_val("wr_data1", S_DATA1, 32'd1);
        exp_val("wr_data2", S_DATA2, 32'd0);
        exp_val("wr_eq", S_EQ, 32'd0);
        drain();

        // beq/bne resolution and branch targets
        write_reg(5'd2, 32'd5);
        write_reg(5'd3, 32'd5);
        id_if.instruction = 32'h1043_0004;
        id_if.PCPlus4D    = 32'h0000_0100;
        exp_val("beq_pcsrc", S_PCSRC, 32'd1);
        exp_val("beq_target", S_PCBR, 32'h0000_0110);
        exp_val("beq_eq", S_EQ, 32'd1);
        drain();
        id_if.instruction = 32'h1043_FFFF;
        exp_val("beq_neg_target", S_PCBR, 32'h0000_00FC);
        exp_val("beq_neg_pcsrc", S_PCSRC, 32'd1);
        drain();
        id_if.instruction = 32'h1443_0004;
        exp_val("bne_eq_pcsrc", S_PCSRC, 32'd0);
        exp_val("bne_target", S_PCBR, 32'h0000_0110);
        drain();
        write_reg(5'd3, 32'd7);
        exp_val("bne_ne_pcsrc", S_PCSRC, 32'd1);
        exp_val("bne_data2", S_DATA2, 32'd7);
        drain();
        id_if.instruction = 32'h1043_0004;
        exp_val("beq_ne_pcsrc", S_PCSRC, 32'd0);
        drain();

        // r0 ignores writes, including through the bypass
        id_if.instruction = 32'h0000_0820;
        @(negedge clk);
        id_if.RegWriteW = 1'b1;
        id_if.WriteRegW = 5'd0;
        id_if.ResultW   = 32'hDEAD_BEEF;
        exp_val("r0_bypass", S_DATA1, 32'd0);
        drain();
        @(posedge clk);
        #1;
        id_if.RegWriteW = 1'b0;
        exp_val("r0_read", S_DATA1, 32'd0);
        drain();

        // Hazard detection
        id_if.instruction = 32'h0043_0820;
        id_if.MemReadE    = 1'b1;
        id_if.WriteRegE   = 5'd3;
        exp_val("lu_rt_haz", S_HAZ, 32'd1);
        drain();
        id_if.WriteRegE = 5'd4;
        exp_val("lu_nomatch_haz", S_HAZ, 32'd0);
        drain();
        id_if.WriteRegE = 5'd2;
        exp_val("lu_rs_haz", S_HAZ, 32'd1);
        drain();
        id_if.instruction = 32'h0843_0000;
        exp_val("lu_jump_haz", S_HAZ, 32'd0);
        drain();
        id_if.instruction = 32'h8C43_0000;
        id_if.WriteRegE   = 5'd3;
        exp_val("lu_lw_rt_haz", S_HAZ, 32'd0);
        drain();
        id_if.WriteRegE = 5'd2;
        exp_val("lu_lw_rs_haz", S_HAZ, 32'd1);
        drain();
        id_if.instruction = 32'h0040_0820;
        id_if.WriteRegE   = 5'd0;
        exp_val("lu_r0_haz", S_HAZ, 32'd0);
        drain();
        id_if.MemReadE    = 1'b0;
        id_if.instruction = 32'h1043_0004;
        id_if.RegWriteE   = 1'b1;
        id_if.WriteRegE   = 5'd2;
        exp_val("br_alu_haz", S_HAZ, 32'd1);
        drain();
        id_if.instruction = 32'h0043_0820;
        exp_val("alu_nobr_haz", S_HAZ, 32'd0);
        drain();
        id_if.instruction = 32'h1443_0004;
        id_if.RegWriteE   = 1'b0;
        id_if.MemReadM    = 1'b1;
        id_if.WriteRegM   = 5'd3;
        exp_val("br_load_haz", S_HAZ, 32'd1);
        drain();
        id_if.WriteRegM = 5'd0;
        exp_val("br_load_r0_haz", S_HAZ, 32'd0);
        drain();
        id_if.MemReadM = 1'b0;

        // Asynchronous reset mid-cycle clears the file without a clock edge
        id_if.instruction = 32'h0043_0820;
        write_reg(5'd2, 32'd9);
        exp_val("pre_rst_data1", S_DATA1, 32'd9);
        exp_val("pre_rst_data2", S_DATA2, 32'd7);
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_val("async_rst_data1", S_DATA1, 32'd0);
        exp_val("async_rst_data2", S_DATA2, 32'd0);
        exp_val("async_rst_eq", S_EQ, 32'd1);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        exp_val("post_rst_data1", S_DATA1, 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
ID stage of the 5-stage MIPS pipeline. Splits the fetched instruction into register fields and reads two operands from an internal 32x32 register file. It also resolves beq/bne early (equality compare and branch target) and flags load-use and branch data hazards to the hazard/stall logic. The register file is written from the WB stage.

Parameters:
DATA_W, 32, datapath and register width
REG_AW, 5, register address width (32 registers)

Ports:
clk  in  1  clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
instruction  in  32  instruction in ID
PCPlus4D  in  32  PC+4 of the instruction in ID
RegWriteW  in  1  WB register write enable
WriteRegW  in  5  WB destination register
ResultW  in  32  WB write data
RegWriteE  in  1  EX-stage instruction writes a register
MemReadE  in  1  EX-stage instruction is a load
WriteRegE  in  5  EX-stage destination register
MemReadM  in  1  MEM-stage instruction is a load
WriteRegM  in  5  MEM-stage destination register
data1  out  32  register file read of rs
data2  out  32  register file read of rt
RsD  out  5  instruction[25:21]
RtD  out  5  instruction[20:16]
RdD  out  5  instruction[15:11]
PCbranchD  out  32  branch target
hazardDetected  out  1  stall request for IF/ID
PCSrcD  out  1  take branch
equalD  out  1  data1 == data2

Behaviour:
- Reset: async, active-low. While rst_n=0, all 32 registers clear to 0. No outputs are registered. After reset with no writes: data1=data2=0, equalD=1, hazardDetected=0 unless driven by the E/M inputs.
- Register file:
  - Two combinational read ports, one write port.
  - Write on rising clk when RegWriteW=1 and WriteRegW!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Write-through bypass: if RegWriteW=1 and WriteRegW equals a nonzero read address, that port returns ResultW in the same cycle.
- Field decode (pure combinational): RsD=instr[25:21], RtD=instr[20:16], RdD=instr[15:11].
- Immediate: signImm = sign-extend instr[15:0] to 32 bits.
- Branch target: PCbranchD = PCPlus4D + (signImm<<2), modulo 2^32 (wrap ignored).
- Branch resolve:
  - equalD = (data1==data2).
  - opcode = instr[31:26]. beq=6'h04, bne=6'h05.
  - PCSrcD = (beq & equalD) | (bne & ~equalD). PCSrcD=0 for all other opcodes.
- Register source usage:
  - usesRs = 1 for every opcode except j (6'h02) and jal (6'h03).
  - usesRt = 1 for R-type (6'h00), beq, bne and sw (6'h2B).
- Hazard detection (combinational):
  - Load-use: MemReadE=1, WriteRegE!=0, and (WriteRegE==RsD with usesRs, or WriteRegE==RtD with usesRt).
  - Branch-ALU: branch opcode, RegWriteE=1, WriteRegE!=0, and WriteRegE matches RsD or RtD.
  - Branch-load: branch opcode, MemReadM=1, WriteRegM!=0, and WriteRegM matches RsD or RtD.
  - hazardDetected = OR of the three terms.
- Stall/flush actions belong to the hazard unit; this block only reports.
- Reset asserted mid-operation clears registers immediately. Combinational outputs follow within the same cycle.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW), field bit positions, DATA_W/REG_AW.
- One sub-module: register_file (32x32, 2R/1W, async reset, write-through bypass, r0 hardwired zero).
- Decode, branch and hazard logic live in instruction_decode.

Test Plan:
1. Reset, instruction=32'h00430820 (add $1,$2,$3) -> RsD=2, RtD=3, RdD=1, data1=0, data2=0, equalD=1, PCSrcD=0, hazardDetected=0.
2. Write reg2=1 (RegWriteW=1, WriteRegW=2, ResultW=1, one posedge) -> data1=1, data2=0, equalD=0. During the write cycle, bypass already gives data1=1.
3. instruction=beq $2,$3,+4 (32'h10430004), PCPlus4D=32'h100, reg2=reg3=5 -> PCSrcD=1, PCbranchD=32'h110. Negative offset 16'hFFFF -> PCbranchD=32'hFC. The same registers with bne -> PCSrcD=0.
4. Write r0 with 32'hDEADBEEF, then read rs=0 -> data1=0.
5. MemReadE=1, WriteRegE=3, ID holds the add -> hazardDetected=1. WriteRegE=4 -> 0. beq with RegWriteE=1, WriteRegE=2 -> 1.
6. Load registers, pulse rst_n low mid-cycle -> all reads return 0 immediately, without waiting for a clock edge.
